val2_shifter_unit: RTL and testbench
====================================

# val2_shifter_unit

Registered, handshaked successor to the combinational Val2 generator in the execute stage. Generates the ALU second operand (val2) and the ARM shifter carry-out from Rm, Rs and the 12-bit shifter-operand field. Covers: rotated 8-bit immediate, shift by immediate with the ARM `#0` encodings (LSR/ASR `#32`, RRX), shift by register (Rs[7:0]), and the load/store offset. Sits between the register-read/ID-EX boundary and the ALU; EX stalls via valid/ready.

## Interface
- `DATA_WIDTH`, 32, operand width; power of two, 8..32.
- `OFFSET_WIDTH`, 12, load/store offset field width; must be ≤ DATA_WIDTH.

- `clk` input 1 rising-edge clock.
- `rst` input 1 asynchronous, active-high reset.
- `in_valid` input 1 request present.
- `in_ready` output 1 request accepted when `in_valid && in_ready` at a rising edge.
- `val_rm` input DATA_WIDTH Rm value.
- `val_rs` input DATA_WIDTH Rs value; only [7:0] used.
- `carry_in` input 1 current CPSR C.
- `instr_shifter_operand` input 12 instruction bits [11:0].
- `instr_is_immediate` input 1 I bit.
- `instr_is_memory_access` input 1 LDR/STR.
- `instr_shift_by_reg` input 1 instruction bit 4 (register-specified shift).
- `out_valid` output 1 result valid.
- `out_ready` input 1 consumer accepts result.
- `val2` output DATA_WIDTH operand.
- `shifter_carry_out` output 1 shifter C.

## Operation
- Fields: imm8=[7:0], rot=[11:8], shamt5=[11:7], type=[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR). The Rs amount is n=val_rs[7:0].
- Priority: memory access > immediate > shift by register > shift by immediate.
- Memory: val2 = offset zero-extended from OFFSET_WIDTH; carry = carry_in.
- Immediate: imm8 zero-extended, rotated right by (2·rot) mod DATA_WIDTH; carry = carry_in if rot==0, else val2[W-1].
- Shift by immediate, with W=DATA_WIDTH:
  - LSL #0 passes Rm with carry_in.
  - LSR #0 and ASR #0 encode a shift of W.
  - ROR #0 is RRX: val2={carry_in, rm[W-1:1]}, carry=rm[0].
  - Any other amount uses the same rules as the register case.
- Shift by register, amount n (0..255):
  - n==0 passes Rm with carry_in, for all types.
  - LSL/LSR with n<W gives the normal shift; carry = last bit shifted out.
  - LSL n==W gives 0 with carry rm[0]. LSR n==W gives 0 with carry rm[W-1]. Either with n>W gives 0 with carry 0.
  - ASR n≥W gives all copies of rm[W-1]; carry = rm[W-1].
  - ROR with n mod W==0 gives Rm with carry rm[W-1]; otherwise rotate by n mod W, carry = val2[W-1].
- FSM states are IDLE, AMT and DONE.
  - IDLE: accepted register-shift request goes to AMT. Amount is clamped to min(n, W+1) and registered, along with Rm, type and carry_in. Any other accepted request is computed and registered, then goes to DONE.
  - AMT: computes from the registered clamped amount, goes to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE, or accept a new request in the same cycle.
- `in_ready` = (state==IDLE) || (state==DONE && out_ready). It is 0 in AMT and while `rst` is high.
- val2 and carry stay stable while out_valid && !out_ready.

## Timing
- Reset (async) sets state=IDLE, out_valid=0, val2=0, shifter_carry_out=0. Reset mid-AMT or mid-DONE discards the operation.
- Latency from accept edge to out_valid:
  - 1 cycle for memory, immediate and shift-by-immediate.
  - 2 cycles for shift-by-register.
- Throughput with out_ready held high: 1 request/cycle for non-register forms; 1 per 2 cycles for register shifts.
- Accept and drain in the same cycle (DONE, out_ready=1, in_valid=1): the new result replaces the old one, with no bubble.
- Inputs are sampled only on the accept edge. Changes to inputs afterwards have no effect.

## Configuration
- The macro is `VAL2_SHIFT_BY_REG_EN`.
- When defined, behaviour is as above.
- When undefined:
  - `instr_shift_by_reg` and `val_rs` are ignored.
  - Every non-memory, non-immediate request is treated as shift by immediate.
  - AMT is never entered, so all latency is 1 cycle.

## Test plan
- Reset: assert rst mid-AMT → out_valid=0, val2=0, carry=0 immediately; in_ready=1 the first cycle after release.
- Immediate: imm8=0xFF, rot=4, carry_in=0 → val2=0xFF000000, carry=1, out_valid one cycle after accept.
- RRX: rm=0x00000003, carry_in=1, ROR #0 → val2=0x80000001, carry=1. ASR #0 on 0x80000000 → 0xFFFFFFFF, carry=1.
- Register shift: rm=0x80000001, Rs=32, LSR → val2=0, carry=1, 2 cycles after accept. Rs=33 → carry=0. ROR with Rs=64 → val2=rm, carry=1.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → val2 stable, in_ready=0. Raising out_ready gives back-to-back immediate results with no bubble.
- Memory: offset=0xFFF with I=1 also set → val2=0x00000FFF, carry=carry_in. With the macro undefined, Rs-shift encoding with shamt5=4, LSL on 1 → 0x10 in 1 cycle.

Source files
------------

// File: rtl/val2_shifter_unit_if.sv
// ============================================================================
// Module      : val2_shifter_unit_if
// Description : Request/response bundle for the Val2 shifter unit. The
//               request side carries the operand fields sampled on accept;
//               the response side carries val2 and the shifter carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface val2_shifter_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] val_rm;
  logic [DATA_WIDTH-1:0] val_rs;
  logic                  carry_in;
  logic [11:0]           instr_shifter_operand;
  logic                  instr_is_immediate;
  logic                  instr_is_memory_access;
  logic                  instr_shift_by_reg;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] val2;
  logic                  shifter_carry_out;

  // Producer of requests / consumer of results (the pipeline around EX)
  modport master (
    output in_valid, val_rm, val_rs, carry_in, instr_shifter_operand,
           instr_is_immediate, instr_is_memory_access, instr_shift_by_reg,
           out_ready,
    input  in_ready, out_valid, val2, shifter_carry_out
  );

  // The shifter unit itself
  modport slave (
    input  in_valid, val_rm, val_rs, carry_in, instr_shifter_operand,
           instr_is_immediate, instr_is_memory_access, instr_shift_by_reg,
           out_ready,
    output in_ready, out_valid, val2, shifter_carry_out
  );
endinterface

`default_nettype wire

// File: rtl/val2_shifter_unit.sv
// ============================================================================
// Module      : val2_shifter_unit
// Description : Registered ARM Val2 / shifter-carry generator with valid/ready
//               handshake. Memory offset, rotated immediate and shift by
//               immediate finish in one cycle; register-specified shifts take
//               an extra AMT cycle. Register shifts are built only when the
//               macro VAL2_SHIFT_BY_REG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module val2_shifter_unit #(
  parameter int DATA_WIDTH   = 32,
  parameter int OFFSET_WIDTH = 12
) (
  input  wire logic          clk,
  input  wire logic          rst,
  val2_shifter_unit_if.slave bus
);

  localparam int c_log2w = $clog2(DATA_WIDTH);
  localparam int c_amt_w = $clog2(DATA_WIDTH + 2);   // holds 0..W+1
  localparam logic [c_amt_w-1:0] c_amt_full = c_amt_w'(DATA_WIDTH);
  localparam logic [c_amt_w-1:0] c_amt_over = c_amt_w'(DATA_WIDTH + 1);
  localparam logic [7:0]         c_n_max    = 8'(DATA_WIDTH + 1);
  localparam logic [1:0] c_lsl = 2'b00;
  localparam logic [1:0] c_lsr = 2'b01;
  localparam logic [1:0] c_asr = 2'b10;
  localparam logic [1:0] c_ror = 2'b11;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_amt  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  // Reduce a shift amount to 0..W+1. Anything above W behaves like W+1 for
  // the linear shifts; ROR only cares about n mod W, with a nonzero multiple
  // of W kept as W so it still differs from the n==0 pass-through.
  function automatic logic [c_amt_w-1:0] f_clamp(input logic [1:0] typ,
                                                 input logic [7:0] n);
    logic [c_log2w-1:0] m;
    m = n[c_log2w-1:0];
    if (n == 8'd0)        f_clamp = '0;
    else if (typ == c_ror) f_clamp = (m == '0) ? c_amt_full : c_amt_w'(m);
    else if (n > c_n_max)  f_clamp = c_amt_over;
    else                   f_clamp = c_amt_w'(n);
  endfunction

  // Register-shift semantics on a clamped amount; returns {carry, value}.
  function automatic logic [DATA_WIDTH:0] f_shift(input logic [DATA_WIDTH-1:0] rm,
                                                  input logic [1:0]            typ,
                                                  input logic [c_amt_w-1:0]    amt,
                                                  input logic                  cin);
    logic [DATA_WIDTH:0]   t;
    logic [DATA_WIDTH-1:0] v;
    logic                  c;
    t = '0;
    v = rm;
    c = cin;
    if (amt != '0) begin
      case (typ)
        c_lsl: begin
          t = {1'b0, rm} << amt;
          if (amt < c_amt_full)       begin v = t[DATA_WIDTH-1:0]; c = t[DATA_WIDTH]; end
          else if (amt == c_amt_full) begin v = '0; c = rm[0]; end
          else                        begin v = '0; c = 1'b0; end
        end
        c_lsr: begin
          t = {rm, 1'b0} >> amt;
          if (amt < c_amt_full)       begin v = t[DATA_WIDTH:1]; c = t[0]; end
          else if (amt == c_amt_full) begin v = '0; c = rm[DATA_WIDTH-1]; end
          else                        begin v = '0; c = 1'b0; end
        end
        c_asr: begin
          t = $signed({rm, 1'b0}) >>> amt;
          if (amt < c_amt_full) begin v = t[DATA_WIDTH:1]; c = t[0]; end
          else begin v = {DATA_WIDTH{rm[DATA_WIDTH-1]}}; c = rm[DATA_WIDTH-1]; end
        end
        default: begin
          if (amt >= c_amt_full) begin v = rm; c = rm[DATA_WIDTH-1]; end
          else begin
            v = (rm >> amt) | (rm << (DATA_WIDTH - int'(amt)));
            c = v[DATA_WIDTH-1];
          end
        end
      endcase
    end
    f_shift = {c, v};
  endfunction

  logic [1:0]            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_val2, r_rm;
  logic                  r_carry, r_cin;
  logic [1:0]            r_type;
  logic [c_amt_w-1:0]    r_amt;
  logic                  w_in_ready, w_out_valid, w_accept, w_is_reg;
  logic [c_amt_w-1:0]    w_rs_amt, w_imm_amt;
  logic [DATA_WIDTH:0]   w_direct, w_amt_res;
  logic [DATA_WIDTH-1:0] w_imm_ext, w_imm_rot;
  logic [c_log2w-1:0]    w_rot_m;
  logic [4:0]            w_shamt;
  logic [1:0]            w_type;
  logic                  w_unused_inputs;

  assign w_shamt = bus.instr_shifter_operand[11:7];
  assign w_type  = bus.instr_shifter_operand[6:5];

`ifdef VAL2_SHIFT_BY_REG_EN
  assign w_is_reg = !bus.instr_is_memory_access && !bus.instr_is_immediate &&
                    bus.instr_shift_by_reg;
  assign w_rs_amt = f_clamp(w_type, bus.val_rs[7:0]);
`else
  assign w_is_reg = 1'b0;
  assign w_rs_amt = '0;
`endif
  // Only val_rs[7:0] matters, and nothing of Rs when register shifts are off
  assign w_unused_inputs = ^{bus.val_rs, bus.instr_shift_by_reg};

  assign w_accept = bus.in_valid && w_in_ready;

  // Immediate form: 8-bit value rotated right by twice the 4-bit field, mod W
  assign w_imm_ext = DATA_WIDTH'(bus.instr_shifter_operand[7:0]);
  assign w_rot_m   = c_log2w'({bus.instr_shifter_operand[11:8], 1'b0});
  assign w_imm_rot = (w_rot_m == '0) ? w_imm_ext :
                     ((w_imm_ext >> w_rot_m) | (w_imm_ext << (DATA_WIDTH - int'(w_rot_m))));

  // Shift-by-immediate amount: LSR/ASR #0 mean a full-width shift
  assign w_imm_amt = ((w_shamt == 5'd0) && ((w_type == c_lsr) || (w_type == c_asr))) ?
                     c_amt_full : f_clamp(w_type, {3'b000, w_shamt});

  // Single-cycle result for every request that does not need the AMT cycle
  always_comb begin
    w_direct = '0;
    if (bus.instr_is_memory_access)
      w_direct = {bus.carry_in, DATA_WIDTH'(bus.instr_shifter_operand[OFFSET_WIDTH-1:0])};
    else if (bus.instr_is_immediate)
      w_direct = {(bus.instr_shifter_operand[11:8] == 4'd0) ? bus.carry_in
                                                            : w_imm_rot[DATA_WIDTH-1],
                  w_imm_rot};
    else if ((w_type == c_ror) && (w_shamt == 5'd0))
      w_direct = {bus.val_rm[0], bus.carry_in, bus.val_rm[DATA_WIDTH-1:1]};  // RRX
    else
      w_direct = f_shift(bus.val_rm, w_type, w_imm_amt, bus.carry_in);
  end

  // Register-shift result from the operands captured on accept
  assign w_amt_res = f_shift(r_rm, r_type, r_amt, r_cin);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_nxt = w_is_reg ? c_st_amt : c_st_done;
      c_st_amt:  w_state_nxt = c_st_done;
      c_st_done: if (bus.out_ready)
                   w_state_nxt = w_accept ? (w_is_reg ? c_st_amt : c_st_done) : c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Handshake outputs decoded from state; nothing is accepted during reset
  always_comb begin
    w_out_valid = (r_state == c_st_done);
    w_in_ready  = !rst && ((r_state == c_st_idle) ||
                           ((r_state == c_st_done) && bus.out_ready));
  end

  // Datapath: capture shift operands or the finished result on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val2  <= '0;
      r_carry <= 1'b0;
      r_rm    <= '0;
      r_type  <= 2'b00;
      r_amt   <= '0;
      r_cin   <= 1'b0;
    end else if (r_state == c_st_amt) begin
      {r_carry, r_val2} <= w_amt_res;
    end else if (w_accept) begin
      if (w_is_reg) begin
        r_rm   <= bus.val_rm;
        r_type <= w_type;
        r_amt  <= w_rs_amt;
        r_cin  <= bus.carry_in;
      end else begin
        {r_carry, r_val2} <= w_direct;
      end
    end
  end

  assign bus.in_ready          = w_in_ready;
  assign bus.out_valid         = w_out_valid;
  assign bus.val2              = r_val2;
  assign bus.shifter_carry_out = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_val2_shifter_unit.sv
// ============================================================================
// Module      : tb_val2_shifter_unit
// Description : Directed self-checking bench for val2_shifter_unit with
//               hand-computed expected values (DATA_WIDTH = 32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_val2_shifter_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  val2_shifter_unit_if #(.DATA_WIDTH(32)) bus ();

  val2_shifter_unit #(.DATA_WIDTH(32), .OFFSET_WIDTH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] so_sh(input logic [4:0] shamt, input logic [1:0] typ);
    so_sh = {shamt, typ, 1'b0, 4'h0};
  endfunction

  task automatic req(input logic mem, input logic imm, input logic sbr, input logic [11:0] so,
                     input logic [31:0] rm, input logic [31:0] rs, input logic cin);
    bus.instr_is_memory_access = mem;
    bus.instr_is_immediate     = imm;
    bus.instr_shift_by_reg     = sbr;
    bus.instr_shifter_operand  = so;
    bus.val_rm                 = rm;
    bus.val_rs                 = rs;
    bus.carry_in               = cin;
  endtask

  // Issue the current request, measure latency, check result, then drain
  task automatic run(input string tag, input int exp_lat, input logic [31:0] exp_v,
                     input logic exp_c);
    int lat;
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 6) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".val2"}, bus.val2, exp_v);
    check({tag, ".carry"}, 32'(bus.shifter_carry_out), 32'(exp_c));
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    req(1'b0, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    check("reset.out_valid", 32'(bus.out_valid), 32'd0);
    check("reset.val2", bus.val2, 32'h0);
    check("reset.carry", 32'(bus.shifter_carry_out), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b0;
    #1 check("release.in_ready", 32'(bus.in_ready), 32'd1);
    tick();

    // Immediate forms
    req(1'b0, 1'b1, 1'b0, 12'h4FF, 32'h0, 32'h0, 1'b0);
    run("imm_rot4", 1, 32'hFF00_0000, 1'b1);
    req(1'b0, 1'b1, 1'b0, 12'h05A, 32'h0, 32'h0, 1'b1);
    run("imm_rot0", 1, 32'h0000_005A, 1'b1);

    // Shift by immediate, including the #0 encodings
    req(1'b0, 1'b0, 1'b0, so_sh(5'd0, 2'b11), 32'h0000_0003, 32'h0, 1'b1);
    run("rrx", 1, 32'h8000_0001, 1'b1);
    req(1'b0, 1'b0, 1'b0, so_sh(5'd0, 2'b10), 32'h8000_0000, 32'h0, 1'b0);
    run("asr0", 1, 32'hFFFF_FFFF, 1'b1);
    req(1'b0, 1'b0, 1'b0, so_sh(5'd0, 2'b01), 32'h7FFF_FFFF, 32'h0, 1'b1);
    run("lsr0", 1, 32'h0000_0000, 1'b0);
    req(1'b0, 1'b0, 1'b0, so_sh(5'd0, 2'b00), 32'h0000_1234, 32'h0, 1'b1);
    run("lsl0", 1, 32'h0000_1234, 1'b1);
    req(1'b0, 1'b0, 1'b0, so_sh(5'd4, 2'b00), 32'hF000_0001, 32'h0, 1'b0);
    run("lsl4", 1, 32'h0000_0010, 1'b1);
    req(1'b0, 1'b0, 1'b0, so_sh(5'd1, 2'b01), 32'h0000_0003, 32'h0, 1'b0);
    run("lsr1", 1, 32'h0000_0001, 1'b1);
    req(1'b0, 1'b0, 1'b0, so_sh(5'd8, 2'b11), 32'h0000_00AB, 32'h0, 1'b0);
    run("ror8", 1, 32'hAB00_0000, 1'b1);
    req(1'b0, 1'b0, 1'b0, so_sh(5'd4, 2'b10), 32'h8000_0010, 32'h0, 1'b1);
    run("asr4", 1, 32'hF800_0001, 1'b0);

    // Memory offset takes priority over the I bit
    req(1'b1, 1'b1, 1'b0, 12'hFFF, 32'hDEAD_BEEF, 32'h0, 1'b1);
    run("mem", 1, 32'h0000_0FFF, 1'b1);

`ifdef VAL2_SHIFT_BY_REG_EN
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b01), 32'h8000_0001, 32'd32, 1'b0);
    run("rs_lsr32", 2, 32'h0, 1'b1);
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b01), 32'h8000_0001, 32'd33, 1'b1);
    run("rs_lsr33", 2, 32'h0, 1'b0);
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b11), 32'h8000_0001, 32'd64, 1'b0);
    run("rs_ror64", 2, 32'h8000_0001, 1'b1);
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b00), 32'h8000_0001, 32'd32, 1'b0);
    run("rs_lsl32", 2, 32'h0, 1'b1);
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b10), 32'h8000_0001, 32'd200, 1'b0);
    run("rs_asr200", 2, 32'hFFFF_FFFF, 1'b1);
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b10), 32'h1234_5678, 32'h100, 1'b1);
    run("rs_n0", 2, 32'h1234_5678, 1'b1);
    // Inputs change after accept: result must come from the sampled values
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b01), 32'h0000_0100, 32'd4, 1'b1);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b00), 32'hFFFF_FFFF, 32'd0, 1'b0);
    tick();
    check("rs_hold.out_valid", 32'(bus.out_valid), 32'd1);
    check("rs_hold.val2", bus.val2, 32'h0000_0010);
    check("rs_hold.carry", 32'(bus.shifter_carry_out), 32'd0);
    tick();
`else
    // Register-shift encoding falls back to shift by immediate
    req(1'b0, 1'b0, 1'b1, so_sh(5'd4, 2'b00), 32'h0000_0001, 32'hFF, 1'b1);
    run("noreg_lsl4", 1, 32'h0000_0010, 1'b0);
`endif

    // Backpressure, then back-to-back immediates with no bubble
    bus.out_ready = 1'b0;
    req(1'b0, 1'b1, 1'b0, 12'h012, 32'h0, 32'h0, 1'b0);
    bus.in_valid = 1'b1;
    tick();
    req(1'b0, 1'b1, 1'b0, 12'h134, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_ready", 32'(bus.in_ready), 32'd0);
      check("bp.out_valid", 32'(bus.out_valid), 32'd1);
      check("bp.val2", bus.val2, 32'h0000_0012);
      tick();
    end
    bus.out_ready = 1'b1;
    #1 check("bp.release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("b2b.first_valid", 32'(bus.out_valid), 32'd1);
    check("b2b.first_val2", bus.val2, 32'h0000_000D);
    req(1'b0, 1'b1, 1'b0, 12'h101, 32'h0, 32'h0, 1'b0);
    tick();
    check("b2b.second_valid", 32'(bus.out_valid), 32'd1);
    check("b2b.second_val2", bus.val2, 32'h4000_0000);
    bus.in_valid = 1'b0;
    tick();
    check("b2b.drained", 32'(bus.out_valid), 32'd0);

    // Reset in the middle of an operation discards it
`ifdef VAL2_SHIFT_BY_REG_EN
    req(1'b0, 1'b0, 1'b1, so_sh(5'd0, 2'b00), 32'hFFFF_FFFF, 32'd1, 1'b1);
`else
    req(1'b0, 1'b1, 1'b0, 12'h0FF, 32'h0, 32'h0, 1'b1);
`endif
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.val2", bus.val2, 32'h0);
    check("midrst.carry", 32'(bus.shifter_carry_out), 32'd0);
    check("midrst.in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst = 1'b0;
    #1 check("midrst.release_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("midrst.stays_idle", 32'(bus.out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 reached");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
